// File: rtl/if_fetch_if.sv
// -----------------------------------------------------------------------------
// if_fetch_if : instruction-memory bus between the fetch stage and imem.
//
// Signals
//   imem_req   fetch -> mem  request valid
//   imem_addr  fetch -> mem  word address of the request
//   imem_ack   mem -> fetch  request complete, imem_rdata valid this cycle
//   imem_rdata mem -> fetch  fetched instruction word
//
// Handshake: the requester raises imem_req with imem_addr and holds both
// stable until the cycle in which imem_ack is high; that cycle completes the
// transfer (ack may coincide with the first request cycle). imem_ack is only
// meaningful while imem_req is high, and at most one request is outstanding.
//
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch : instruction fetch stage.
//
// Owns the program counter, issues one-outstanding requests to instruction
// memory and registers each returned word together with its PC+4 into the
// outputs feeding the IF_ID pipeline register. Supports stall (hold outputs,
// no new request) and redirect (flush and restart at redirect_pc); priority
// is reset > redirect > stall > normal.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   stall           hold outputs, do not launch a new request
//   redirect        flush and restart fetch at redirect_pc
//   redirect_pc     target address, bits [1:0] ignored
//   mem             imem bus (if_fetch_if.master)
//   valid_out       instr_out/pc_out hold a real instruction
//   instr_out       fetched instruction (NOP on bubbles)
//   pc_out          fetch address + 4 (modulo 2^32)
//   state_dbg       current FSM state: 0 IDLE, 1 REQ, 2 HOLD, 3 DROP
// -----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  if_fetch_if.master        mem,
  output logic              valid_out,
  output logic [31:0]       instr_out,
  output logic [31:0]       pc_out,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] drop_addr, drop_addr_d;   // address of the abandoned request
  logic [31:0] buf_instr, buf_instr_d;   // word captured while stalled
  logic [31:0] buf_pc, buf_pc_d;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_out_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;

  assign pc_plus4     = pc + 32'd4;
  assign redirect_tgt = redirect_pc & ~32'd3;

  // In DROP the old request is still on the bus, so its address must be
  // presented even though pc already points at the redirect target.
  assign mem.imem_req  = (state == S_REQ) || (state == S_DROP);
  assign mem.imem_addr = (state == S_DROP) ? drop_addr : pc;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
      buf_instr <= NOP;
      buf_pc    <= 32'd0;
      valid_out <= 1'b0;
      instr_out <= NOP;
      pc_out    <= 32'd0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      drop_addr <= drop_addr_d;
      buf_instr <= buf_instr_d;
      buf_pc    <= buf_pc_d;
      valid_out <= valid_d;
      instr_out <= instr_d;
      pc_out    <= pc_out_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    drop_addr_d = drop_addr;
    buf_instr_d = buf_instr;
    buf_pc_d    = buf_pc;
    valid_d     = valid_out;
    instr_d     = instr_out;
    pc_out_d    = pc_out;

    // Flush common to every state: bubble on the outputs, empty buffer,
    // restart address loaded. pc_out is left as is on a bubble.
    if (redirect) begin
      valid_d     = 1'b0;
      instr_d     = NOP;
      buf_instr_d = NOP;
      buf_pc_d    = 32'd0;
      pc_d        = redirect_tgt;
    end

    case (state)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect) begin
          if (!mem.imem_ack) begin
            // Old request still pending: finish it on the bus, drop its data.
            state_d     = S_DROP;
            drop_addr_d = pc;
          end
        end else if (stall) begin
          if (mem.imem_ack) begin
            buf_instr_d = mem.imem_rdata;
            buf_pc_d    = pc_plus4;
            pc_d        = pc_plus4;
            state_d     = S_HOLD;
          end
        end else if (mem.imem_ack) begin
          valid_d  = 1'b1;
          instr_d  = mem.imem_rdata;
          pc_out_d = pc_plus4;
          pc_d     = pc_plus4;
        end else begin
          valid_d = 1'b0;
          instr_d = NOP;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (!stall) begin
          valid_d     = 1'b1;
          instr_d     = buf_instr;
          pc_out_d    = buf_pc;
          buf_instr_d = NOP;
          buf_pc_d    = 32'd0;
          state_d     = S_REQ;
        end
      end

      S_DROP: begin
        // A redirect here only retargets pc; the bus keeps the old request.
        // Once the old request acks, fetching resumes at pc, which already
        // includes any redirect seen in this same cycle.
        if (mem.imem_ack) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch : self-checking bench for if_fetch.
// Directed steps from the test plan, then a randomized phase checked against
// a transaction-level model: every new valid output must be the next word of
// the architectural instruction stream (sequential from the last redirect or
// reset), carrying fetch address + 4.
// -----------------------------------------------------------------------------
module tb_if_fetch;

  localparam logic [31:0] NOP_W = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid_out,   valid_out_w;
  logic [31:0] instr_out,   instr_out_w;
  logic [31:0] pc_out,      pc_out_w;
  logic [1:0]  state_dbg,   state_dbg_w;

  if_fetch_if bus();
  if_fetch_if bus_w();

  if_fetch u_dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem         (bus),
    .valid_out   (valid_out),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .state_dbg   (state_dbg)
  );

  // Second instance exercising a reset address at the top of memory.
  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem         (bus_w),
    .valid_out   (valid_out_w),
    .instr_out   (instr_out_w),
    .pc_out      (pc_out_w),
    .state_dbg   (state_dbg_w)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];     // expected instruction stream addresses
  logic        model_on = 1'b0;
  logic        m_prev_hold = 1'b0;
  int          deliveries = 0;
  int          gap = 0;
  int          max_gap = 0;

  // memory model state
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [31:0] saddr = 32'd0;
  logic        ack_q = 1'b0;
  logic        rst_q = 1'b1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: memf = 32'h2008_000A;
      32'h0000_0004: memf = 32'h2009_0014;
      32'h0000_0008: memf = 32'h0109_5020;
      32'h0000_000C: memf = 32'h012A_5822;
      default:       memf = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pco);
    chk({tag, "_valid"}, {31'd0, valid_out}, {31'd0, v});
    chk({tag, "_instr"}, instr_out, ins);
    chk({tag, "_pc_out"}, pc_out, pco);
  endtask

  // One clock cycle: drive inputs and memory responses after the rising edge,
  // then sample outputs on the falling edge.
  task automatic cyc(input logic r, input logic st, input logic rd,
                     input logic [31:0] rpc, input int l);
    @(posedge clk);
    #1;
    reset       = r;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;

    if (rst_q || ack_q) busy = 1'b0;
    if (busy) begin
      chk("mem_req_held", {31'd0, bus.imem_req}, 32'd1);
      chk("mem_addr_stable", bus.imem_addr, saddr);
      if (cnt > 0) cnt--;
    end else if (bus.imem_req) begin
      busy  = 1'b1;
      cnt   = l;
      saddr = bus.imem_addr;
    end
    bus.imem_ack   = busy && (cnt == 0);
    bus.imem_rdata = bus.imem_ack ? memf(saddr) : 32'hDEAD_BEEF;
    ack_q = bus.imem_ack;
    rst_q = r;

    bus_w.imem_ack   = bus_w.imem_req;
    bus_w.imem_rdata = memf(bus_w.imem_addr);

    @(negedge clk);
    if (model_on) begin
      if (valid_out && !m_prev_hold) begin
        chk("model_instr", instr_out, memf(exp_q[0]));
        chk("model_pc_out", pc_out, exp_q[0] + 32'd4);
        exp_q[0] = exp_q[0] + 32'd4;
        deliveries++;
        gap = 0;
      end else if (!st) begin
        gap++;
      end
      if (!valid_out) chk("model_bubble_nop", instr_out, NOP_W);
      if (r) begin
        exp_q[0] = 32'd0;
        gap = 0;
      end else if (rd) begin
        exp_q[0] = rpc & ~32'd3;
        gap = 0;
      end
      if (gap > max_gap) max_gap = gap;
      m_prev_hold = st && !rd && !r;
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic r, st, rd;
    logic [31:0] rpc;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
    bus_w.imem_ack = 1'b0; bus_w.imem_rdata = 32'd0;
    exp_q.push_back(32'd0);

    // Reset values
    do_reset();
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    chk_out("rst", 1'b0, NOP_W, 32'd0);
    chk("rst_w_addr", bus_w.imem_addr, 32'hFFFF_FFFC);

    // Zero-wait memory: one instruction per cycle
    cyc(0, 0, 0, 0, 0);                                     // cycle 0
    chk("zw_c0_req", {31'd0, bus.imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0);                                     // cycle 1
    chk("zw_c1_req", {31'd0, bus.imem_req}, 32'd1);
    chk("zw_c1_addr", bus.imem_addr, 32'h0);
    chk_out("zw_c1", 1'b0, NOP_W, 32'd0);
    cyc(0, 0, 0, 0, 0);                                     // cycle 2
    chk_out("zw_c2", 1'b1, 32'h2008_000A, 32'h4);
    chk("zw_c2_addr", bus.imem_addr, 32'h4);
    cyc(0, 0, 0, 0, 0);                                     // cycle 3
    chk_out("zw_c3", 1'b1, 32'h2009_0014, 32'h8);
    chk("zw_c3_addr", bus.imem_addr, 32'h8);

    // Stall for 3 cycles while addr C acks
    cyc(0, 1, 0, 0, 0);                                     // cycle 4
    chk_out("zw_c4", 1'b1, 32'h0109_5020, 32'hC);
    chk("zw_c4_addr", bus.imem_addr, 32'hC);
    cyc(0, 1, 0, 0, 0);                                     // cycle 5 HOLD
    chk("st_c5_req", {31'd0, bus.imem_req}, 32'd0);
    chk_out("st_c5", 1'b1, 32'h0109_5020, 32'hC);
    cyc(0, 1, 0, 0, 0);                                     // cycle 6
    chk_out("st_c6", 1'b1, 32'h0109_5020, 32'hC);
    cyc(0, 0, 0, 0, 0);                                     // cycle 7 stall falls
    chk("st_c7_req", {31'd0, bus.imem_req}, 32'd0);
    chk_out("st_c7", 1'b1, 32'h0109_5020, 32'hC);
    cyc(0, 0, 0, 0, 0);                                     // cycle 8
    chk_out("st_c8", 1'b1, 32'h012A_5822, 32'h10);
    chk("st_c8_req", {31'd0, bus.imem_req}, 32'd1);
    chk("st_c8_addr", bus.imem_addr, 32'h10);

    // Two-cycle ack latency
    do_reset();
    cyc(0, 0, 0, 0, 2);                                     // cycle 0
    for (int i = 1; i <= 10; i++) begin
      logic        v;
      logic [31:0] pe;
      cyc(0, 0, 0, 0, 2);
      v  = (i >= 4) && (((i - 4) % 3) == 0);
      pe = (i >= 4) ? 32'(4 * ((i - 1) / 3)) : 32'd0;
      chk_out("lat2", v, v ? memf(pe - 32'd4) : NOP_W, pe);
      chk("lat2_addr", bus.imem_addr, 32'(4 * ((i - 1) / 3)));
    end

    // Redirect to 0x40 during an outstanding request at addr 8
    do_reset();
    cyc(0, 0, 0, 0, 0);                                     // cycle 0
    cyc(0, 0, 0, 0, 0);                                     // cycle 1
    cyc(0, 0, 0, 0, 0);                                     // cycle 2
    cyc(0, 0, 1, 32'h40, 2);                                // cycle 3
    chk("rd_c3_addr", bus.imem_addr, 32'h8);
    chk_out("rd_c3", 1'b1, 32'h2009_0014, 32'h8);
    cyc(0, 0, 0, 0, 0);                                     // cycle 4 DROP
    chk("rd_c4_addr", bus.imem_addr, 32'h8);
    chk_out("rd_c4", 1'b0, NOP_W, 32'h8);
    cyc(0, 0, 0, 0, 0);                                     // cycle 5 old ack
    chk("rd_c5_addr", bus.imem_addr, 32'h8);
    cyc(0, 0, 0, 0, 0);                                     // cycle 6
    chk("rd_c6_addr", bus.imem_addr, 32'h40);
    chk("rd_c6_valid", {31'd0, valid_out}, 32'd0);
    cyc(0, 0, 0, 0, 0);                                     // cycle 7
    chk_out("rd_c7", 1'b1, memf(32'h40), 32'h44);

    // Redirect and stall together in HOLD: flush wins
    do_reset();
    cyc(0, 0, 0, 0, 0);                                     // cycle 0
    cyc(0, 0, 0, 0, 0);                                     // cycle 1
    cyc(0, 1, 0, 0, 0);                                     // cycle 2 ack addr 4 -> HOLD
    cyc(0, 1, 1, 32'h103, 0);                               // cycle 3
    chk("rs_c3_req", {31'd0, bus.imem_req}, 32'd0);
    chk_out("rs_c3", 1'b1, 32'h2008_000A, 32'h4);
    cyc(0, 0, 0, 0, 0);                                     // cycle 4
    chk("rs_c4_valid", {31'd0, valid_out}, 32'd0);
    chk("rs_c4_instr", instr_out, NOP_W);
    chk("rs_c4_addr", bus.imem_addr, 32'h100);
    cyc(0, 0, 0, 0, 0);                                     // cycle 5
    chk_out("rs_c5", 1'b1, memf(32'h100), 32'h104);

    // Reset mid-request; wrap instance fetching from 0xFFFFFFFC
    do_reset();
    cyc(0, 0, 0, 0, 3);                                     // cycle 0
    cyc(0, 0, 0, 0, 3);                                     // cycle 1
    chk("mr_c1_req", {31'd0, bus.imem_req}, 32'd1);
    cyc(1, 0, 0, 0, 3);                                     // cycle 2 reset driven
    chk("wr_c2_valid", {31'd0, valid_out_w}, 32'd1);
    chk("wr_c2_addr", bus_w.imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0);                                     // cycle 3
    chk("mr_req", {31'd0, bus.imem_req}, 32'd0);
    chk("mr_addr", bus.imem_addr, 32'h0);
    chk("mr_state", {30'd0, state_dbg}, 32'd0);
    chk_out("mr", 1'b0, NOP_W, 32'd0);
    chk("wr_req", {31'd0, bus_w.imem_req}, 32'd0);
    chk("wr_addr", bus_w.imem_addr, 32'hFFFF_FFFC);
    chk("wr_valid", {31'd0, valid_out_w}, 32'd0);
    chk("wr_instr", instr_out_w, NOP_W);
    chk("wr_pc_out", pc_out_w, 32'd0);
    cyc(0, 0, 0, 0, 0);                                     // cycle 4
    chk("wr_c4_addr", bus_w.imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);                                     // cycle 5
    chk("wr_c5_valid", {31'd0, valid_out_w}, 32'd1);
    chk("wr_c5_instr", instr_out_w, memf(32'hFFFF_FFFC));
    chk("wr_c5_pc_out", pc_out_w, 32'd0);
    chk("wr_c5_addr", bus_w.imem_addr, 32'd0);

    // Randomized phase against the stream model
    do_reset();
    exp_q[0]    = 32'd0;
    m_prev_hold = 1'b0;
    gap         = 0;
    model_on    = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           rpc = $urandom & 32'h0000_0FFF;
      cyc(r, st, rd, rpc, int'($urandom_range(0, 3)));
    end
    model_on = 1'b0;
    chk("rand_max_gap_ok", {31'd0, (max_gap <= 30)}, 32'd1);
    chk("rand_enough_deliveries", {31'd0, (deliveries >= 200)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage. Owns the program counter and issues one-outstanding requests to instruction memory. Registers each returned word with its PC+4 into the outputs that feed the IF_ID pipeline register (instr_in/pc_in). Supports back-pressure (stall) from the hazard unit and branch/jump redirect from a later stage.

## Interface
- RESET_PC, 32'h00000000, first fetch address after reset
- NOP, 32'h00000000, instruction word driven on bubbles/flush
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold outputs, do not launch new request
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  target address (word aligned, bits[1:0] ignored)
- imem_req  out  1  request valid
- imem_addr  out  32  request address
- imem_ack  in  1  request complete, imem_rdata valid this cycle
- imem_rdata  in  32  fetched word
- valid_out  out  1  instr_out/pc_out hold a real instruction
- instr_out  out  32  fetched instruction to IF_ID
- pc_out  out  32  fetch address + 4 to IF_ID

## Operation
- States:
  - IDLE: one cycle after reset, no request.
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: word captured in a one-entry buffer while stalled; imem_req=0.
  - DROP: redirect arrived mid-request; finish the old request and discard its data.
- Memory protocol:
  - imem_req and imem_addr stay stable until the imem_ack cycle.
  - Ack may arrive in the same cycle as the request or any later cycle.
  - At most one request is outstanding.
- Transitions and priority (redirect > stall > normal):
  - IDLE → REQ unconditionally. A redirect in IDLE loads pc=redirect_pc.
  - REQ, ack, no stall, no redirect:
    - outputs ← {1, imem_rdata, pc+4}
    - pc ← pc+4
    - stay in REQ; the next request issues the following cycle.
  - REQ, no ack, no stall: valid_out←0, instr_out←NOP, pc_out holds.
  - REQ with stall: outputs hold.
    - With ack: buffer ← {imem_rdata, pc+4}, pc ← pc+4, → HOLD.
    - Without ack: stay in REQ with the request still held.
  - HOLD, stall=1: outputs and buffer hold.
  - HOLD, stall=0: outputs ← {1, buffer}, → REQ.
  - redirect in any state:
    - next cycle valid_out=0, instr_out=NOP
    - buffer cleared
    - pc ← {redirect_pc[31:2],2'b00}
  - Redirect from REQ with ack the same cycle: data discarded, → REQ at the new pc.
  - Redirect from REQ without ack: → DROP, keeping the old addr on the bus.
  - Redirect from HOLD or DROP: discard, → REQ (HOLD) or stay in DROP.
  - DROP with ack: data discarded, → REQ at the saved pc.
- Arithmetic:
  - pc+4 is modulo 2^32; 32'hFFFFFFFC wraps to 0.
  - pc_out = fetch address + 4, same wrap.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC
  - imem_req=0, imem_addr=RESET_PC
  - valid_out=0, instr_out=NOP, pc_out=0
  - buffer empty
- Reset mid-operation abandons any outstanding request. imem_req is 0 the next cycle.
- Zero-wait memory (ack in the request cycle):
  - Reset deasserted before edge 0; IDLE at cycle 0, first req at cycle 1.
  - valid_out=1 at cycle 2; throughput is one instruction per cycle.
- Latency: ack at cycle N → valid_out/instr_out/pc_out updated at cycle N+1 (when not stalled).
- Stall release: the buffered word appears 1 cycle after stall falls; the next request issues in that same cycle.
- Redirect latency: a redirect at cycle N gives a bubble at N+1.
  - No outstanding request: req at redirect_pc at N+1.
  - Old request outstanding: req at redirect_pc the cycle after the old ack.

## Test plan
- Reset, zero-wait memory returning 32'h2008000A, 32'h20090014, 32'h01095020 → outputs (1,2008000A,00000004), (1,20090014,00000008), (1,01095020,0000000C) on consecutive cycles; imem_addr 0,4,8.
- Memory with 2-cycle ack latency → imem_addr stable while waiting, valid_out=0/instr_out=NOP between instructions, pc_out sequence 4,8,C.
- Stall high for 3 cycles while ack arrives for 32'h012A5822 at addr C → outputs hold previous word; imem_req=0 in HOLD; the word appears with pc_out=10 one cycle after stall falls.
- Redirect to 32'h00000040 during an outstanding request at addr 8 (ack 2 cycles later) → imem_addr stays 8 until ack, data dropped, next imem_addr=40, first valid pc_out=44.
- Redirect and stall asserted together in HOLD → flush wins: valid_out=0, buffer discarded, fetch at redirect_pc.
- Reset asserted mid-request, plus RESET_PC=32'hFFFFFFFC → all outputs return to reset values the next cycle; first fetch at FFFFFFFC gives pc_out=0, next imem_addr=0.
